// File: rtl/gps_pkg.sv
// -----------------------------------------------------------------------------
// gps_pkg
// Shared definitions for the GPS signal generator PRNG sequencer.
//   ST_IDLE / ST_RUN / ST_DONE : sequencer state encoding
//   *_BITS_DEF                 : default widths for divider, burst length and
//                                period counter
// -----------------------------------------------------------------------------
package gps_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DIV_BITS_DEF = 8;
    localparam int LEN_BITS_DEF = 16;
    localparam int CNT_BITS_DEF = 32;

endpackage

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Turns PRNG epoch strobes into a registered epoch marker and measures the
// number of steps between consecutive epochs.
// Ports:
//   clk_in           in   system clock
//   rst_in_n         in   asynchronous active-low reset
//   clr              in   restart measurement (new run)
//   step             in   PRNG step strobe
//   epoch            in   PRNG start pulse (only honoured together with step)
//   epoch_out        out  one-cycle pulse the cycle after an epoch step
//   period_out       out  steps between the last two epochs (saturating)
//   period_valid_out out  period_out holds a measured value
// -----------------------------------------------------------------------------
module period_meter
    import gps_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                clr,
    input  logic                step,
    input  logic                epoch,
    output logic                epoch_out,
    output logic [CNT_BITS-1:0] period_out,
    output logic                period_valid_out
);

    logic [CNT_BITS-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic [CNT_BITS-1:0] per_inc;
    logic                first_q, first_d;
    logic                valid_q, valid_d;
    logic                epoch_q;
    logic                epoch_step;

    // An epoch only counts when the PRNG actually stepped this cycle.
    assign epoch_step = step & epoch;

    // Saturating increment; shared by the running count and the period load,
    // so a period longer than the counter reads back as all-ones.
    assign per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_BITS'(1);

    always_comb begin
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        first_d   = first_q;
        valid_d   = valid_q;
        if (clr) begin
            // period_out is deliberately kept so software can still read the
            // last measurement; only its valid flag is withdrawn.
            per_cnt_d = '0;
            first_d   = 1'b0;
            valid_d   = 1'b0;
        end else if (epoch_step) begin
            per_cnt_d = '0;
            first_d   = 1'b1;
            if (first_q) begin
                period_d = per_inc;
                valid_d  = 1'b1;
            end
        end else if (step) begin
            per_cnt_d = per_inc;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            first_q   <= 1'b0;
            valid_q   <= 1'b0;
            epoch_q   <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            first_q   <= first_d;
            valid_q   <= valid_d;
            epoch_q   <= epoch_step;
        end
    end

    assign epoch_out        = epoch_q;
    assign period_out       = period_q;
    assign period_valid_out = valid_q;

endmodule

// File: rtl/prng_ctrl.sv
// -----------------------------------------------------------------------------
// prng_ctrl
// Sequencer for the LFSR PRNG: generates the step-enable strobe at a
// programmable sub-rate of clk_in, runs finite bursts or continuously, and
// reports epochs and the measured code period.
// Ports:
//   clk_in           in   system clock
//   rst_in_n         in   asynchronous active-low reset
//   start_in         in   one-cycle run command (IDLE only)
//   stop_in          in   abort command (any state)
//   div_in           in   step every div_in+1 clocks, latched on start
//   len_in           in   steps per burst, 0 = continuous, latched on start
//   prng_start_in    in   PRNG start pulse (enable AND initial state)
//   prng_ena_out     out  PRNG enable strobe, one cycle per step
//   busy_out         out  high in RUN and DONE
//   done_out         out  one-cycle pulse when a finite burst completes
//   epoch_out        out  one-cycle pulse the cycle after an epoch step
//   period_out       out  steps between the last two epochs
//   period_valid_out out  period_out holds a measured value
// -----------------------------------------------------------------------------
module prng_ctrl
    import gps_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_DEF,
    parameter int LEN_BITS = LEN_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic [DIV_BITS-1:0] div_in,
    input  logic [LEN_BITS-1:0] len_in,
    input  logic                prng_start_in,
    output logic                prng_ena_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                epoch_out,
    output logic [CNT_BITS-1:0] period_out,
    output logic                period_valid_out
);

    logic [1:0]          state_q, state_d;
    logic [DIV_BITS-1:0] div_lat_q, div_lat_d;
    logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic [LEN_BITS-1:0] len_lat_q, len_lat_d;
    logic [LEN_BITS-1:0] step_cnt_q, step_cnt_d;
    logic                strobe;
    logic                meter_clr;
    logic                burst_end;

    // Pure register decode: the strobe must not depend combinationally on
    // any input, so the PRNG enable is glitch-free and timing-clean.
    assign strobe = (state_q == ST_RUN) && (div_cnt_q == div_lat_q);

    // Finite burst finishes when this strobe brings the step count to len.
    assign burst_end = strobe && (len_lat_q != '0) &&
                       ((step_cnt_q + LEN_BITS'(1)) == len_lat_q);

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        div_lat_d  = div_lat_q;
        len_lat_d  = len_lat_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        meter_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop_in wins over a simultaneous start_in.
                if (start_in && !stop_in) begin
                    state_d    = ST_RUN;
                    div_lat_d  = div_in;
                    len_lat_d  = len_in;
                    div_cnt_d  = '0;
                    step_cnt_d = '0;
                    meter_clr  = 1'b1;
                end
            end

            ST_RUN: begin
                if (strobe) begin
                    div_cnt_d  = '0;
                    // In continuous mode the step count is free to wrap.
                    step_cnt_d = step_cnt_q + LEN_BITS'(1);
                end else begin
                    div_cnt_d = div_cnt_q + DIV_BITS'(1);
                end

                if (stop_in) begin
                    state_d = ST_IDLE;
                end else if (burst_end) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Single-cycle state; start_in is ignored here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= ST_IDLE;
            div_lat_q  <= '0;
            len_lat_q  <= '0;
            div_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of
            // them update from the same pre-edge values.
            state_q    <= state_d;
            div_lat_q  <= div_lat_d;
            len_lat_q  <= len_lat_d;
            div_cnt_q  <= div_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    period_meter #(
        .CNT_BITS (CNT_BITS)
    ) u_period_meter (
        .clk_in           (clk_in),
        .rst_in_n         (rst_in_n),
        .clr              (meter_clr),
        .step             (strobe),
        .epoch            (prng_start_in),
        .epoch_out        (epoch_out),
        .period_out       (period_out),
        .period_valid_out (period_valid_out)
    );

    assign prng_ena_out = strobe;
    assign busy_out     = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done_out     = (state_q == ST_DONE);

endmodule

// File: tb/tb_prng_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prng_ctrl
// Directed self-checking bench for prng_ctrl. A 4-bit maximal-length LFSR
// (x^4 + x^3 + 1, period 15) stands in for the PRNG on the main instance; a
// second instance with CNT_BITS = 4 exercises period saturation.
// -----------------------------------------------------------------------------
module tb_prng_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in_n;

    // Main instance (default widths)
    logic        start_in, stop_in;
    logic [7:0]  div_in;
    logic [15:0] len_in;
    logic        prng_start_in;
    logic        prng_ena_out, busy_out, done_out, epoch_out, period_valid_out;
    logic [31:0] period_out;

    // Saturation instance (CNT_BITS = 4)
    logic        start4, stop4, ps4;
    logic [7:0]  div4;
    logic [15:0] len4;
    logic        ena4, busy4, done4, epoch4, valid4;
    logic [3:0]  period4;

    // PRNG model
    logic [3:0]  lfsr;
    logic        prng_link;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    prng_ctrl u_dut (
        .clk_in           (clk_in),
        .rst_in_n         (rst_in_n),
        .start_in         (start_in),
        .stop_in          (stop_in),
        .div_in           (div_in),
        .len_in           (len_in),
        .prng_start_in    (prng_start_in),
        .prng_ena_out     (prng_ena_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .epoch_out        (epoch_out),
        .period_out       (period_out),
        .period_valid_out (period_valid_out)
    );

    prng_ctrl #(
        .CNT_BITS (4)
    ) u_dut4 (
        .clk_in           (clk_in),
        .rst_in_n         (rst_in_n),
        .start_in         (start4),
        .stop_in          (stop4),
        .div_in           (div4),
        .len_in           (len4),
        .prng_start_in    (ps4),
        .prng_ena_out     (ena4),
        .busy_out         (busy4),
        .done_out         (done4),
        .epoch_out        (epoch4),
        .period_out       (period4),
        .period_valid_out (valid4)
    );

    always @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            lfsr <= 4'b0001;
        end else if (prng_link && prng_ena_out) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign prng_start_in = prng_link && prng_ena_out && (lfsr == 4'b0001);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_run(input logic [7:0] d, input logic [15:0] l);
        div_in   = d;
        len_in   = l;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"},    32'(prng_ena_out),     32'd0);
        check({tag, "_busy"},   32'(busy_out),         32'd0);
        check({tag, "_done"},   32'(done_out),         32'd0);
        check({tag, "_epoch"},  32'(epoch_out),        32'd0);
        check({tag, "_period"}, period_out,            32'd0);
        check({tag, "_valid"},  32'(period_valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in_n  = 1'b0;
        start_in  = 1'b0;
        stop_in   = 1'b0;
        div_in    = '0;
        len_in    = '0;
        prng_link = 1'b0;
        start4    = 1'b0;
        stop4     = 1'b0;
        ps4       = 1'b0;
        div4      = '0;
        len4      = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("rst");
        check("rst_busy4",   32'(busy4),   32'd0);
        check("rst_period4", 32'(period4), 32'd0);
        rst_in_n = 1'b1;
        tick();

        // Reset mid-RUN, div 3, continuous
        start_run(8'd3, 16'd0);
        for (int c = 1; c <= 6; c++) begin
            check("mr_ena", 32'(prng_ena_out), 32'(c == 4));
            check("mr_busy", 32'(busy_out), 32'd1);
            if (c < 6) tick();
        end
        rst_in_n = 1'b0;
        #1;
        check_all_zero("mr_async");
        tick();
        rst_in_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("mr_post_ena",  32'(prng_ena_out), 32'd0);
            check("mr_post_busy", 32'(busy_out),     32'd0);
        end

        // Burst div 0, len 5
        start_run(8'd0, 16'd5);
        for (int c = 1; c <= 5; c++) begin
            check("b5_ena",  32'(prng_ena_out), 32'd1);
            check("b5_busy", 32'(busy_out),     32'd1);
            check("b5_done", 32'(done_out),     32'd0);
            tick();
        end
        check("b5_done_pulse", 32'(done_out),     32'd1);
        check("b5_done_ena",   32'(prng_ena_out), 32'd0);
        check("b5_done_busy",  32'(busy_out),     32'd1);
        tick();
        check("b5_idle_busy",  32'(busy_out),     32'd0);
        check("b5_idle_done",  32'(done_out),     32'd0);

        // Burst div 2, len 3: strobes on RUN cycles 3, 6, 9
        start_run(8'd2, 16'd3);
        for (int c = 1; c <= 9; c++) begin
            check("b3_ena",  32'(prng_ena_out), 32'((c % 3) == 0));
            check("b3_done", 32'(done_out),     32'd0);
            tick();
        end
        check("b3_done_pulse", 32'(done_out),     32'd1);
        check("b3_done_ena",   32'(prng_ena_out), 32'd0);
        tick();
        check("b3_idle_done",  32'(done_out),     32'd0);
        check("b3_idle_busy",  32'(busy_out),     32'd0);

        // Continuous with 4-bit PRNG: epochs at strobes 1, 16, 31
        prng_link = 1'b1;
        start_run(8'd0, 16'd0);
        for (int c = 1; c <= 40; c++) begin
            check("ep_ena",    32'(prng_ena_out),     32'd1);
            check("ep_epoch",  32'(epoch_out),        32'(c == 2 || c == 17 || c == 32));
            check("ep_valid",  32'(period_valid_out), 32'(c >= 17));
            check("ep_period", period_out,            (c >= 17) ? 32'd15 : 32'd0);
            if (c == 40) stop_in = 1'b1;
            tick();
        end
        stop_in   = 1'b0;
        prng_link = 1'b0;
        check("ep_stop_busy",   32'(busy_out),         32'd0);
        check("ep_stop_ena",    32'(prng_ena_out),     32'd0);
        check("ep_stop_done",   32'(done_out),         32'd0);
        check("ep_stop_period", period_out,            32'd15);
        check("ep_stop_valid",  32'(period_valid_out), 32'd1);

        // Stop in RUN at div 1, on the strobe cycle
        start_run(8'd1, 16'd10);
        check("st_ena_c1", 32'(prng_ena_out), 32'd0);
        tick();
        check("st_ena_c2", 32'(prng_ena_out), 32'd1);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("st_busy",   32'(busy_out),         32'd0);
        check("st_ena",    32'(prng_ena_out),     32'd0);
        check("st_period", period_out,            32'd15);
        check("st_valid",  32'(period_valid_out), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("st_done", 32'(done_out),     32'd0);
            check("st_idle", 32'(prng_ena_out), 32'd0);
            tick();
        end

        // start and stop together in IDLE
        div_in   = 8'd0;
        len_in   = 16'd2;
        start_in = 1'b1;
        stop_in  = 1'b1;
        tick();
        start_in = 1'b0;
        stop_in  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("ss_busy", 32'(busy_out),     32'd0);
            check("ss_ena",  32'(prng_ena_out), 32'd0);
            tick();
        end

        // Saturation, CNT_BITS = 4: epoch pulses at strobes 1 and 21
        div4   = 8'd0;
        len4   = 16'd0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            ps4 = (c == 1 || c == 21);
            check("sat_ena", 32'(ena4), 32'd1);
            if (c == 2) begin
                check("sat_epoch1", 32'(epoch4), 32'd1);
                check("sat_valid1", 32'(valid4), 32'd0);
            end
            tick();
        end
        ps4 = 1'b0;
        check("sat_epoch2", 32'(epoch4),  32'd1);
        check("sat_valid2", 32'(valid4),  32'd1);
        check("sat_period", 32'(period4), 32'd15);
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        check("sat_stop_busy",   32'(busy4),   32'd0);
        check("sat_stop_done",   32'(done4),   32'd0);
        check("sat_stop_period", 32'(period4), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prng_ctrl.md
Name: prng_ctrl

Overview:
- Sequencer for the LFSR PRNG in the GPS signal generator.
- Generates the PRNG step-enable strobe at a programmable sub-rate of clk_in, and runs the PRNG either for a fixed number of steps (burst) or continuously.
- Watches the PRNG start pulse to emit epoch markers and measure the code period, so the top level can align chip/epoch timing and self-check the sequence length.

Parameters:
- DIV_BITS, 8, width of the clock-divider setting.
- LEN_BITS, 16, width of the burst-length setting.
- CNT_BITS, 32, width of the period counter and period_out; must cover the PRNG period.

Ports:
- clk_in  input  1  system clock, all logic rising-edge.
- rst_in_n  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle run command; sampled in IDLE only.
- stop_in  input  1  abort command; sampled in any state.
- div_in  input  DIV_BITS  step every div_in+1 clocks; latched on start.
- len_in  input  LEN_BITS  steps per burst, 0 = continuous; latched on start.
- prng_start_in  input  1  PRNG start_out (its enable ANDed with "state == initial state").
- prng_ena_out  output  1  PRNG enable strobe, one cycle per step.
- busy_out  output  1  high in RUN and DONE.
- done_out  output  1  one-cycle pulse when a finite burst completes.
- epoch_out  output  1  one-cycle pulse, registered, the cycle after an epoch step.
- period_out  output  CNT_BITS  steps between the last two epochs.
- period_valid_out  output  1  period_out holds a measured value.

Behaviour:
- Reset (async, rst_in_n = 0): state IDLE, all counters 0; every output 0, including period_out = 0.
- States are IDLE, RUN and DONE.
- IDLE to RUN: the cycle after start_in = 1 with stop_in = 0.
  - Latches div_lat = div_in and len_lat = len_in.
  - Clears div_cnt, step_cnt, per_cnt, the first-epoch flag and period_valid_out.
  - If stop_in and start_in are high in the same IDLE cycle, stop wins and the block stays in IDLE.
- RUN divider:
  - div_cnt counts 0..div_lat, then wraps to 0.
  - prng_ena_out = (state == RUN) and (div_cnt == div_lat). It is a decode of registers only, with no combinational path from inputs.
  - div_lat = 0 gives prng_ena_out high on every RUN cycle.
  - The first strobe comes div_lat+1 cycles after entering RUN.
- Step counting:
  - step_cnt increments on each strobe.
  - If len_lat != 0 and a strobe brings step_cnt to len_lat, the next state is DONE.
  - A burst therefore produces exactly len_lat strobes.
  - len_lat = 0 runs until stop. step_cnt is don't-care and may wrap.
- DONE: lasts one cycle with done_out = 1, then returns to IDLE. start_in is ignored in DONE.
- stop_in in RUN or DONE: the next state is IDLE.
  - No done_out is issued.
  - No prng_ena_out is issued in the cycle after stop.
  - A strobe in the same cycle as stop_in is still issued.
  - period_out and period_valid_out hold their values.
- Epoch detection:
  - An epoch is prng_ena_out and prng_start_in both high.
  - epoch_out is high the following cycle.
  - prng_start_in is ignored when prng_ena_out = 0.
- Period measurement:
  - On a non-epoch strobe, per_cnt increments, saturating at all-ones.
  - On an epoch strobe, per_cnt is cleared to 0.
  - On an epoch strobe when the first-epoch flag is already set, period_out is loaded with sat(per_cnt + 1) and period_valid_out is set.
  - The first epoch after start only sets the flag.
  - Period updates take effect on the same edge as epoch_out rises.
- Mid-operation reset forces IDLE immediately, with outputs as in reset.
- The PRNG register itself is never reset by this block; only its enable is controlled.

Decomposition:
- Shared package `gps_pkg`:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - default widths DIV_BITS_DEF, LEN_BITS_DEF, CNT_BITS_DEF.
- One sub-module is natural: `period_meter`.
  - Inputs: clk_in, rst_in_n, clr, step, epoch.
  - Outputs: epoch_out, period_out, period_valid_out.
  - Contains per_cnt, the first-epoch flag and saturation.
- The FSM, divider and step counter stay in prng_ctrl.

Test Plan:
- Reset mid-RUN (div_in = 3, len_in = 0), then rst_in_n low for 1 cycle -> all outputs 0 within the same cycle; state IDLE; no strobe until a new start_in.
- div_in = 0, len_in = 5, start_in pulse -> busy_out from the next cycle; prng_ena_out high 5 consecutive cycles; done_out high the cycle after the 5th strobe; busy_out low the cycle after that.
- div_in = 2, len_in = 3 -> strobes 3 cycles apart, the first on the 3rd RUN cycle, exactly 3 strobes, then a single done_out.
- div_in = 0, len_in = 0, driving a maximal-length 4-bit PRNG (period 15) from reset state, run for 40 strobes ->
  - epoch_out at strobes 1, 16 and 31;
  - period_out = 15;
  - period_valid_out rises with the 2nd epoch_out.
- stop_in in RUN at div_in = 1 -> IDLE next cycle; no done_out; period_out held.
- start_in and stop_in high together in IDLE -> stays IDLE.
- Saturation with CNT_BITS = 4 and prng_start_in tied 0 except for two pulses 20 strobes apart -> period_out = 15.
